// File: rtl/ifetch_buffered.sv
// Instruction fetch unit: PC generation, 1-cycle synchronous imem reads, prefetch FIFO
// with redirect flush, and UPG memory-port mux. Define IFETCH_PERF_EN for perf counters.
module ifetch_buffered #(
  parameter int                ADDR_W     = 14,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                PC_STEP    = 4,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] instr_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              imem_en_o,
  output logic              imem_we_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  output logic [DATA_W-1:0] imem_wdata_o,
  input  logic [DATA_W-1:0] imem_rdata_i,
  input  logic              upg_rst_i,
  input  logic              upg_wen_i,
  input  logic [ADDR_W-1:0] upg_addr_i,
  input  logic [DATA_W-1:0] upg_data_i,
`ifdef IFETCH_PERF_EN
  output logic [31:0]       perf_fetch_o,
  output logic [31:0]       perf_stall_o,
`endif
  input  logic              upg_done_i
);

  localparam int                PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(PC_STEP);
  localparam logic [CNT_W:0]    DEPTH_X = (CNT_W+1)'(FIFO_DEPTH);

  typedef enum logic {RUN = 1'b0, LOAD = 1'b1} mode_t;

  mode_t             mode;
  logic              kickoff;
  logic              restart;
  logic              issue;
  logic              push;
  logic              pop;
  logic              flush;
  logic [ADDR_W-1:0] pc;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit;
  logic [DATA_W-1:0] instr_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem  [FIFO_DEPTH];

  assign kickoff = upg_rst_i | upg_done_i;
  // First RUN cycle after a load only reloads the PC; fetch resumes a cycle later.
  assign restart = kickoff && (mode == LOAD);
  assign flush   = !kickoff || redirect_i;
  assign credit  = {1'b0, count} + (CNT_W+1)'(vld_p1);
  assign issue   = !rst_n && kickoff && !restart && !redirect_i && (credit < DEPTH_X);
  assign push    = vld_p1 && !flush;
  assign valid_o = kickoff && (count != '0);
  assign pop     = valid_o && ready_i && !redirect_i;
  assign instr_o = instr_mem[rd_ptr];
  assign addr_o  = addr_mem[rd_ptr];

  always_comb begin
    imem_en_o    = 1'b0;
    imem_we_o    = 1'b0;
    imem_addr_o  = pc;
    imem_wdata_o = '0;
    if (!kickoff && !rst_n) begin
      imem_en_o    = upg_wen_i;
      imem_we_o    = upg_wen_i;
      imem_addr_o  = upg_addr_i;
      imem_wdata_o = upg_data_i;
    end else if (issue) begin
      imem_en_o = 1'b1;
    end
  end

  // Stage p0 -> p1: issue bookkeeping, mode tracking and FIFO control
  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      mode   <= RUN;
      pc     <= RESET_PC;
      vld_p1 <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      mode   <= kickoff ? RUN : LOAD;
      vld_p1 <= issue;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
      if (restart)
        pc <= RESET_PC;
      else if (kickoff && redirect_i)
        pc <= redirect_addr_i;
      else if (issue)
        pc <= pc + STEP;
    end
  end

  always_ff @(posedge clk_i) begin
    addr_p1 <= pc;
  end

  // Stage p1 -> FIFO: the returning read word is paired with its issue address
  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= '0;
        addr_mem[i]  <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr] <= imem_rdata_i;
      addr_mem[wr_ptr]  <= addr_p1;
    end
  end

`ifdef IFETCH_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Counters hold their value while a program load is in progress
  always_ff @(posedge clk_i) begin
    if (rst_n) begin
      perf_fetch_o <= '0;
      perf_stall_o <= '0;
    end else if (kickoff) begin
      if (pop)                 perf_fetch_o <= sat_inc(perf_fetch_o);
      if (valid_o && !ready_i) perf_stall_o <= sat_inc(perf_stall_o);
    end
  end
`endif

endmodule

// File: doc/ifetch_buffered.md
Name: ifetch_buffered

Overview:
- Parametrised next-generation instruction fetch unit.
- Holds the PC and issues reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers fetched instruction/address pairs in a prefetch FIFO and hands them to decode over a valid/ready handshake, with flush on branch redirect.
- Owns the memory-port mux for UART program-upgrade (UPG) loading; all UPG inputs are synchronous to clk_i.

Parameters:
- ADDR_W, 14: PC / memory address width.
- DATA_W, 32: instruction width.
- RESET_PC, 0: PC value after reset and after UPG load completes.
- PC_STEP, 4: sequential PC increment.
- FIFO_DEPTH, 4: prefetch entries; power of two, at least 2.

Ports:
- clk_i  in  1  sole clock.
- rst_n  in  1  reset; synchronous, active-high (1 = reset).
- redirect_i  in  1  branch/jump taken; flush and refetch.
- redirect_addr_i  in  ADDR_W  redirect target.
- ready_i  in  1  decode accepts head entry.
- valid_o  out  1  head entry valid.
- instr_o  out  DATA_W  head instruction.
- addr_o  out  ADDR_W  head instruction address.
- imem_en_o  out  1  memory access strobe.
- imem_we_o  out  1  memory write enable (UPG only).
- imem_addr_o  out  ADDR_W  memory address.
- imem_wdata_o  out  DATA_W  memory write data.
- imem_rdata_i  in  DATA_W  read data, valid the cycle after an en_o=1, we_o=0 access.
- upg_rst_i  in  1  UPG reset (1 = UPG idle).
- upg_wen_i  in  1  UPG write enable.
- upg_addr_i  in  ADDR_W  UPG write address.
- upg_data_i  in  DATA_W  UPG write data.
- upg_done_i  in  1  UPG program load finished.

Behaviour:
Mode select:
- kickoff = upg_rst_i | upg_done_i. Two states: RUN (kickoff=1) and LOAD (kickoff=0).
- LOAD drives imem_en_o=upg_wen_i, imem_we_o=upg_wen_i, imem_addr_o=upg_addr_i, imem_wdata_o=upg_data_i, all combinationally.
- On entry to LOAD: FIFO flushed, in-flight read discarded, valid_o=0.
- LOAD->RUN: pc<=RESET_PC; first issue occurs on the following cycle.

Reset:
- rst_n=1 takes priority over every other input.
- pc=RESET_PC; FIFO empty; in-flight flag cleared; FIFO storage zeroed.
- valid_o=0, instr_o=0, addr_o=0.
- Fetch starts on the first cycle after rst_n falls, if in RUN.

Issue (RUN):
- Issue when no redirect is present and occupancy + inflight < FIFO_DEPTH.
- An issue drives imem_en_o=1, imem_we_o=0, imem_addr_o=pc, and sets pc<=pc+PC_STEP.
- pc wraps modulo 2^ADDR_W.
- When not issuing: imem_en_o=0, imem_addr_o=pc, imem_wdata_o=0.

Response:
- Data returned the cycle after an issue is pushed with its issue address, unless killed.

Output:
- valid_o = FIFO non-empty; instr_o/addr_o = head entry (combinational from storage).
- Pop when valid_o & ready_i.
- Push and pop in the same cycle leave occupancy unchanged; this is legal when full, but the credit rule never overfills.
- Head is stable while valid_o=1 and ready_i=0.

Redirect:
- In the redirect cycle: FIFO cleared (any pop is ignored), in-flight response killed, no issue, pc<=redirect_addr_i.
- Latency, redirect at cycle 0: issue redirect_addr at cycle 1, push at the end of cycle 2, valid_o=1 at cycle 3.
- Redirect during LOAD is ignored.
- Redirect coincident with LOAD->RUN: the LOAD->RUN rule wins (pc=RESET_PC).

Throughput:
- Steady state with ready_i=1: one instruction per cycle.

Optional Feature:
- Macro IFETCH_PERF_EN.
- Defined: adds outputs perf_fetch_o[31:0] and perf_stall_o[31:0].
  - perf_fetch_o counts pops.
  - perf_stall_o counts cycles with valid_o=1 & ready_i=0.
  - Both counters clear on rst_n, freeze in LOAD and saturate at 0xFFFFFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
1. Streaming from reset, ready_i=1, memory returning addr-tagged data -> first valid_o at cycle 2 after reset release with addr_o=0x0000, then addr_o=0x0004, 0x0008 consecutively, one per cycle.
2. Backpressure: ready_i=0 for 10 cycles -> exactly FIFO_DEPTH=4 entries buffered, at most 4 issues, head held at 0x0000. On ready_i=1, addresses 0x0000..0x000C pop in order with none lost or duplicated.
3. Redirect to 0x0100 while FIFO holds 3 entries and a read is in flight -> all stale entries dropped, valid_o low for 2 cycles, next addr_o=0x0100 at cycle 3.
4. PC wrap: redirect to 0x3FFC with ADDR_W=14 -> addr_o sequence 0x3FFC, 0x0000.
5. UPG: upg_rst_i=0, upg_done_i=0, write 0xDEADBEEF to 0x0000 -> imem_we_o=1 and valid_o=0 throughout. Then upg_done_i=1 -> fetch restarts at RESET_PC and instr_o=0xDEADBEEF.
6. Reset asserted mid-stream with a full FIFO -> next cycle valid_o=0, instr_o=0, pc=RESET_PC; with IFETCH_PERF_EN, both counters read 0.
